// File: rtl/bid_memory_master.sv
// bid_memory_master: bus initiator for bid_memory.
// Turns a valid/ready request stream into one-hot-addressed read/write bus
// cycles on a shared tri-state data bus and returns one response per request.
// Optional feature: define BIDM_READBACK_EN to verify every write with a
// readback of the same bank (rsp_err flags a mismatch).
module bid_memory_master #(
  parameter int A_WID  = 5,
  parameter int D_WID  = 8,
  parameter int IDX_W  = 3,
  parameter int RD_CYC = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_wr,
  input  logic [IDX_W-1:0]   req_bank,
  input  logic [D_WID-1:0]   req_wdata,
  output logic               rsp_valid,
  output logic [D_WID-1:0]   rsp_rdata,
  output logic               rsp_err,
  output logic [A_WID-1:0]   addr,
  output logic               wr,
  output logic               rd,
  inout  wire  [D_WID-1:0]   data
);

  // One extra bit so A_WID == 2**IDX_W still compares correctly.
  localparam logic [IDX_W:0] BANK_LIM = (IDX_W+1)'(A_WID);
  localparam logic [1:0]     LAST_STB = 2'(RD_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, W_SETUP, W_STROBE, W_HOLD, R_SETUP, R_STROBE, R_HOLD, TURN
  } state_t;

  state_t             state_q, state_nx;
  logic [IDX_W-1:0]   bank_q;
  logic [D_WID-1:0]   wdata_q;
  logic [D_WID-1:0]   rd_cap_q;
  logic [1:0]         cnt_q, cnt_nx;
  logic [A_WID-1:0]   addr_q, addr_nx;
  logic               wr_q, wr_nx;
  logic               rd_q, rd_nx;
  logic               drive_q, drive_nx;
  logic               ready_q, ready_nx;
  logic               rsp_valid_q, rsp_fire;
  logic [D_WID-1:0]   rsp_rdata_q, rsp_rdata_nx;
  logic               rsp_err_q, rsp_err_nx;
  logic               accept, bank_ok;
  logic [IDX_W-1:0]   bank_sel;
`ifdef BIDM_READBACK_EN
  logic               op_wr_q, bad_q, rb_done_q, rb_start;
`endif

  // ready_q is only ever high in IDLE, so it doubles as the accept qualifier.
  assign accept   = req_valid & ready_q;
  assign bank_ok  = {1'b0, req_bank} < BANK_LIM;
  // On the accept edge the latched bank is not yet valid; use the request.
  assign bank_sel = (state_q == IDLE) ? req_bank : bank_q;

  // Next-state, next bus outputs and response selection.
  always_comb begin
    state_nx     = state_q;
    cnt_nx       = cnt_q;
    rsp_fire     = 1'b0;
    rsp_rdata_nx = '0;
    rsp_err_nx   = 1'b0;
`ifdef BIDM_READBACK_EN
    rb_start     = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (!bank_ok) begin
            state_nx   = TURN;
            rsp_fire   = 1'b1;
            rsp_err_nx = 1'b1;
          end else if (req_wr) begin
            state_nx = W_SETUP;
          end else begin
            state_nx = R_SETUP;
          end
        end
      end
      W_SETUP:  state_nx = W_STROBE;
      W_STROBE: state_nx = W_HOLD;
      W_HOLD: begin
        state_nx = TURN;
`ifndef BIDM_READBACK_EN
        rsp_fire = 1'b1;
`endif
      end
      R_SETUP: begin
        state_nx = R_STROBE;
        cnt_nx   = '0;
      end
      R_STROBE: begin
        if (cnt_q == LAST_STB) state_nx = R_HOLD;
        else                   cnt_nx   = cnt_q + 2'd1;
      end
      R_HOLD: begin
        state_nx     = TURN;
        rsp_fire     = 1'b1;
        rsp_rdata_nx = rd_cap_q;
`ifdef BIDM_READBACK_EN
        rsp_err_nx   = op_wr_q & (rd_cap_q != wdata_q);
`endif
      end
      TURN: begin
`ifdef BIDM_READBACK_EN
        // A verified write passes through TURN once silently, then reads back.
        if (op_wr_q && !bad_q && !rb_done_q) begin
          state_nx = R_SETUP;
          rb_start = 1'b1;
        end else begin
          state_nx = IDLE;
        end
`else
        state_nx = IDLE;
`endif
      end
      default: state_nx = IDLE;
    endcase

    addr_nx = '0;
    if (state_nx inside {W_SETUP, W_STROBE, W_HOLD, R_SETUP, R_STROBE, R_HOLD})
      addr_nx = A_WID'(1) << bank_sel;
    wr_nx    = (state_nx == W_STROBE);
    rd_nx    = (state_nx == R_STROBE);
    drive_nx = state_nx inside {W_SETUP, W_STROBE, W_HOLD};
    ready_nx = (state_nx == IDLE);
  end

  // State, registered outputs, request latch and read-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bank_q      <= '0;
      wdata_q     <= '0;
      rd_cap_q    <= '0;
      cnt_q       <= '0;
      addr_q      <= '0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      drive_q     <= 1'b0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef BIDM_READBACK_EN
      op_wr_q     <= 1'b0;
      bad_q       <= 1'b0;
      rb_done_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_nx;
      cnt_q       <= cnt_nx;
      addr_q      <= addr_nx;
      wr_q        <= wr_nx;
      rd_q        <= rd_nx;
      drive_q     <= drive_nx;
      ready_q     <= ready_nx;
      rsp_valid_q <= rsp_fire;
      if (accept) begin
        bank_q  <= req_bank;
        wdata_q <= req_wdata;
      end
      if (state_q == R_STROBE && cnt_q == LAST_STB)
        rd_cap_q <= data;
      if (rsp_fire) begin
        rsp_rdata_q <= rsp_rdata_nx;
        rsp_err_q   <= rsp_err_nx;
      end
`ifdef BIDM_READBACK_EN
      if (accept) begin
        op_wr_q   <= req_wr;
        bad_q     <= ~bank_ok;
        rb_done_q <= 1'b0;
      end else if (rb_start) begin
        rb_done_q <= 1'b1;
      end
`endif
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign addr      = addr_q;
  assign wr        = wr_q;
  assign rd        = rd_q;
  assign data      = drive_q ? wdata_q : 'z;

endmodule

// File: tb/tb_bid_memory_master.sv
// Testbench for bid_memory_master with a behavioural bank memory on the bus.
// Requests are issued by a driver that pushes expected responses into a
// scoreboard queue; a monitor pops and compares on every rsp_valid.
module tb_bid_memory_master;
  localparam int RD_CYC = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_wr;
  logic [2:0] req_bank;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic [4:0] addr;
  logic       wr;
  logic       rd;
  wire  [7:0] data;

  bid_memory_master #(.A_WID(5), .D_WID(8), .IDX_W(3), .RD_CYC(RD_CYC)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_bank(req_bank), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .addr(addr), .wr(wr), .rd(rd), .data(data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural bank memory: writes on wr edges, drives the bus while rd.
  logic [7:0] mem_q [5] = '{default: 8'h00};
  logic [7:0] mem_out;
  logic [7:0] flip = 8'h00;
  always_comb begin
    mem_out = 8'h00;
    for (int i = 0; i < 5; i++) if (addr[i]) mem_out = mem_q[i];
  end
  assign data = rd ? (mem_out ^ flip) : 8'bz;
  always @(posedge clk) begin
    for (int i = 0; i < 5; i++) if (wr && addr[i]) mem_q[i] <= data;
  end

  typedef struct {
    logic [7:0] rdata;
    logic [7:0] alt;
    bit         has_alt;
    bit         err;
    int         lat;
    int         acc;
    int         wr_n;
    int         rd_n;
    logic [4:0] addr;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] exp_mem [5] = '{default: 8'h00};
  int         checks = 0;
  int         errors = 0;
  int         prev_acc = 0;
  int         prev_lat = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  // Issue one request (called at a negedge); expectation comes from exp_mem.
  task automatic issue(input bit w, input logic [2:0] b, input logic [7:0] d,
                       input bit chained, input bit use_alt, input logic [7:0] alt);
    exp_t e;
    int t = 0;
    req_valid = 1'b1; req_wr = w; req_bank = b; req_wdata = d;
    while (!req_ready && t < 200) begin @(negedge clk); t++; end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got ready=0 expected ready=1 within 200 cycles");
      req_valid = 1'b0;
      return;
    end
    e.acc = cyc; e.alt = 8'h00; e.has_alt = 1'b0;
    if (b >= 5) begin
      e.rdata = 8'h00; e.err = 1'b1; e.lat = 1; e.wr_n = 0; e.rd_n = 0; e.addr = 5'b0;
    end else if (w) begin
      exp_mem[b] = d;
      e.addr = 5'b00001 << b; e.wr_n = 1;
`ifdef BIDM_READBACK_EN
      e.rdata = d ^ flip; e.err = (flip != 8'h00); e.lat = 7 + RD_CYC; e.rd_n = RD_CYC;
`else
      e.rdata = 8'h00; e.err = 1'b0; e.lat = 4; e.rd_n = 0;
`endif
    end else begin
      e.rdata = exp_mem[b] ^ flip; e.err = 1'b0; e.lat = 3 + RD_CYC;
      e.wr_n = 0; e.rd_n = RD_CYC; e.addr = 5'b00001 << b;
      if (use_alt) begin e.alt = alt; e.has_alt = 1'b1; end
    end
    if (chained) chk("b2b_period", 32'(e.acc - prev_acc), 32'(prev_lat + 1));
    prev_acc = e.acc; prev_lat = e.lat;
    sb.push_back(e);
    @(negedge clk);
    chk("ready_low_busy", {31'b0, req_ready}, 32'd0);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 1000) begin @(negedge clk); t++; end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
  endtask

  // Monitor: bus protocol per cycle, scoreboard compare on each response.
  initial begin
    int wr_n = 0, rd_n = 0;
    logic [4:0] addr_or = 5'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        wr_n = 0; rd_n = 0; addr_or = 5'b0;
      end else begin
        chk("wr_rd_overlap", {31'b0, wr & rd}, 32'd0);
        if (wr) wr_n++;
        if (rd) rd_n++;
        addr_or |= addr;
        if (rsp_valid) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_rsp: got rsp_valid=1 expected none pending");
          end else begin
            e = sb.pop_front();
            chk("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
            if (e.has_alt) begin
              checks++;
              if (rsp_rdata !== e.rdata && rsp_rdata !== e.alt) begin
                errors++;
                $display("FAIL rsp_rdata_alt: got %0h expected %0h or %0h", rsp_rdata, e.rdata, e.alt);
              end
            end else begin
              chk("rsp_rdata", {24'b0, rsp_rdata}, {24'b0, e.rdata});
            end
            chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
            chk("wr_cycles", 32'(wr_n), 32'(e.wr_n));
            chk("rd_cycles", 32'(rd_n), 32'(e.rd_n));
            chk("addr_seen", {27'b0, addr_or}, {27'b0, e.addr});
          end
          wr_n = 0; rd_n = 0; addr_or = 5'b0;
        end
      end
    end
  end

  initial begin
    logic [7:0] vals [5] = '{8'hA1, 8'hB1, 8'hC1, 8'hD1, 8'hE1};
    logic [7:0] old;
    logic [2:0] b;
    rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_bank = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_addr", {27'b0, addr}, 32'd0);
    chk("rst_wr", {31'b0, wr}, 32'd0);
    chk("rst_rd", {31'b0, rd}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", {24'b0, rsp_rdata}, 32'd0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {31'b0, req_ready}, 32'd1);

    // Writes then reads of every bank.
    for (int i = 0; i < 5; i++) issue(1'b1, 3'(i), vals[i], 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) issue(1'b0, 3'(i), 8'h00, 1'b0, 1'b0, 8'h00);
    // Illegal bank indices.
    issue(1'b0, 3'd5, 8'h00, 1'b0, 1'b0, 8'h00);
    issue(1'b1, 3'd7, 8'h3C, 1'b0, 1'b0, 8'h00);
    drain();

    // Ten mixed requests with req_valid held high throughout.
    for (int i = 0; i < 10; i++) begin
      b = ($urandom_range(0, 5) == 5) ? 3'd6 : 3'($urandom_range(0, 4));
      issue(1'($urandom_range(0, 1)), b, 8'($urandom), i > 0, 1'b0, 8'h00);
    end
    drain();

    // Reset asserted during the write strobe.
    old = exp_mem[3];
    issue(1'b1, 3'd3, 8'h77, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    chk("w_strobe_seen", {31'b0, wr}, 32'd1);
    rst = 1'b1;
    void'(sb.pop_back());
    @(negedge clk);
    chk("abort_wr", {31'b0, wr}, 32'd0);
    chk("abort_addr", {27'b0, addr}, 32'd0);
    chk("abort_rsp", {31'b0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    issue(1'b0, 3'd3, 8'h00, 1'b0, 1'b1, old);
    issue(1'b1, 3'd3, 8'h33, 1'b0, 1'b0, 8'h00);
    drain();

    // Randomized traffic with idle gaps.
    for (int i = 0; i < 30; i++) begin
      b = ($urandom_range(0, 7) < 6) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
      issue(1'($urandom_range(0, 1)), b, 8'($urandom), 1'b0, 1'b0, 8'h00);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

`ifdef BIDM_READBACK_EN
    issue(1'b1, 3'd2, 8'h5A, 1'b0, 1'b0, 8'h00);
    drain();
    flip = 8'h01;
    issue(1'b1, 3'd2, 8'h5A, 1'b0, 1'b0, 8'h00);
    drain();
    flip = 8'h00;
`endif

    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish before time limit");
    $fatal(1);
  end
endmodule
